// File: rtl/spi_word_queue.sv
// spi_word_queue: FIFO of 32-bit words issued one at a time to an SPI
// serializer through its wr/data strobe interface. The serializer has no
// ready output, so issues are paced by watching its chip-select line.
//
// Ports:
//   clk_i, rst_n         clock, synchronous active-low reset
//   wr_i, data_i         push strobe and word
//   flush_i              clears queue contents and sticky flags
//   full_o, empty_o      queue status (registered)
//   level_o              words currently queued (registered)
//   overflow_o           sticky: push attempted while full
//   timeout_o            sticky: serializer cs did not fall after an issue
//   ser_wr_o, ser_data_o issue strobe and word to the serializer
//   ser_cs_i             serializer chip-select feedback (active low)
module spi_word_queue #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned START_TIMEOUT = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
    input  logic                    wr_i,
    input  logic [31:0]             data_i,
    input  logic                    flush_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    overflow_o,
    output logic                    timeout_o,
    output logic                    ser_wr_o,
    output logic [31:0]             ser_data_o,
    input  logic                    ser_cs_i
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TMO_W  = $clog2(START_TIMEOUT + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   timer_q, timer_d, timer_inc;
    logic [GAP_W-1:0]   gap_q, gap_d, gap_inc;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WORD_W-1:0]  mem [DEPTH];
    logic               issue;
    logic               tmo_set;
    logic               push;

    // Push qualification uses the registered full flag, so a same-cycle pop
    // never frees a slot for a push into a full queue.
    assign push      = wr_i && !full_o && !flush_i;
    assign timer_inc = timer_q + TMO_W'(1);
    assign gap_inc   = gap_q + GAP_W'(1);

    // Issue pacing FSM: next state, issue/pop and timeout decisions
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        gap_d   = gap_q;
        issue   = 1'b0;
        tmo_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Flush wins over an issue in the same cycle
                if (count_q != CNT_W'(0) && ser_cs_i && !flush_i) begin
                    issue   = 1'b1;
                    timer_d = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (!ser_cs_i) begin
                    state_d = ST_BUSY;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TMO_W'(START_TIMEOUT)) begin
                        tmo_set = 1'b1;
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_BUSY: begin
                if (ser_cs_i) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_d = gap_inc;
                if (gap_inc == GAP_W'(GAP_CYCLES)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Occupancy update
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push && !issue) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && issue) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Word storage; contents are don't-care outside the pointer window
    always_ff @(posedge clk_i) begin
        if (rst_n && push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // State, pointers, flags and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            gap_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_o     <= 1'b0;
            empty_o    <= 1'b1;
            level_o    <= '0;
            overflow_o <= 1'b0;
            timeout_o  <= 1'b0;
            ser_wr_o   <= 1'b0;
            ser_data_o <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            gap_q    <= gap_d;
            count_q  <= count_d;
            full_o   <= (count_d == CNT_W'(DEPTH));
            empty_o  <= (count_d == CNT_W'(0));
            level_o  <= count_d;
            ser_wr_o <= issue;
            if (issue) begin
                ser_data_o <= mem[rd_ptr_q];
            end
            if (flush_i) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                overflow_o <= 1'b0;
                timeout_o  <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (issue) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                if (wr_i && full_o) begin
                    overflow_o <= 1'b1;
                end
                if (tmo_set) begin
                    timeout_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_word_queue.sv
// Directed testbench for spi_word_queue with a small behavioural serializer
// (cs low for 32 spi_clk periods, bits captured on spi_clk rising edges).
module tb_spi_word_queue;

    localparam int unsigned DEPTH         = 8;
    localparam int unsigned GAP_CYCLES    = 4;
    localparam int unsigned START_TIMEOUT = 64;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        flush_i = 1'b0;
    logic        full_o;
    logic        empty_o;
    logic [3:0]  level_o;
    logic        overflow_o;
    logic        timeout_o;
    logic        ser_wr_o;
    logic [31:0] ser_data_o;
    logic        ser_cs_i;

    int n_checks = 0;
    int n_pass   = 0;

    // cs source: behavioural serializer or a manually held level
    logic use_model = 1'b1;
    logic man_cs    = 1'b1;
    logic model_cs  = 1'b1;
    logic spi_clk   = 1'b0;
    logic [31:0] sh = '0;
    logic [31:0] cap = '0;
    int   bitn  = 0;
    int   rises = 0;
    logic [31:0] rx_q[$];
    int   rxbits_q[$];

    int n_issue = 0;
    int hi_run  = 0;
    int gap_q[$];

    assign ser_cs_i = use_model ? model_cs : man_cs;

    always #5 clk_i = ~clk_i;

    spi_word_queue #(
        .DEPTH(DEPTH),
        .GAP_CYCLES(GAP_CYCLES),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .wr_i(wr_i),
        .data_i(data_i),
        .flush_i(flush_i),
        .full_o(full_o),
        .empty_o(empty_o),
        .level_o(level_o),
        .overflow_o(overflow_o),
        .timeout_o(timeout_o),
        .ser_wr_o(ser_wr_o),
        .ser_data_o(ser_data_o),
        .ser_cs_i(ser_cs_i)
    );

    // Behavioural serializer: latch on wr, shift 32 bits MSB first
    always @(posedge clk_i) begin
        if (!rst_n || !use_model) begin
            model_cs <= 1'b1;
            spi_clk  <= 1'b0;
            bitn     <= 0;
        end else if (model_cs) begin
            if (ser_wr_o) begin
                model_cs <= 1'b0;
                sh       <= ser_data_o;
                bitn     <= 0;
                rises    <= 0;
                spi_clk  <= 1'b0;
            end
        end else if (!spi_clk) begin
            spi_clk <= 1'b1;
            cap     <= {cap[30:0], sh[31]};
            rises   <= rises + 1;
        end else begin
            spi_clk <= 1'b0;
            sh      <= sh << 1;
            bitn    <= bitn + 1;
            if (bitn == 31) begin
                model_cs <= 1'b1;
                rx_q.push_back(cap);
                rxbits_q.push_back(rises);
            end
        end
    end

    // Issue log: count strobes and the cs-high run preceding each one
    always @(posedge clk_i) begin
        if (!rst_n) begin
            hi_run = 0;
        end else begin
            if (ser_wr_o) begin
                n_issue++;
                gap_q.push_back(hi_run);
            end
            if (ser_cs_i) hi_run++;
            else hi_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_rx(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (rx_q.size() < target && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (rx_q.size() < target) $display("FAIL %s rx_count got %0d exp %0d", name, rx_q.size(), target);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ticks(2);
        n_checks++; if (level_o !== 4'd0) $display("FAIL rst_level got %0d exp 0", level_o); else n_pass++;
        n_checks++; if (empty_o !== 1'b1) $display("FAIL rst_empty got %b exp 1", empty_o); else n_pass++;
        n_checks++; if (full_o !== 1'b0) $display("FAIL rst_full got %b exp 0", full_o); else n_pass++;
        n_checks++; if (overflow_o !== 1'b0) $display("FAIL rst_overflow got %b exp 0", overflow_o); else n_pass++;
        n_checks++; if (timeout_o !== 1'b0) $display("FAIL rst_timeout got %b exp 0", timeout_o); else n_pass++;
        n_checks++; if (ser_wr_o !== 1'b0) $display("FAIL rst_ser_wr got %b exp 0", ser_wr_o); else n_pass++;
        n_checks++; if (ser_data_o !== 32'h0) $display("FAIL rst_ser_data got %h exp 0", ser_data_o); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int rx_base, iss_base;
        rx_base  = rx_q.size();
        iss_base = n_issue;
        use_model = 1'b1;
        wr_i = 1'b1; data_i = 32'hABCDEF01;
        tick();
        wr_i = 1'b0; data_i = '0;
        n_checks++; if (level_o !== 4'd1) $display("FAIL single_level1 got %0d exp 1", level_o); else n_pass++;
        n_checks++; if (empty_o !== 1'b0) $display("FAIL single_empty got %b exp 0", empty_o); else n_pass++;
        n_checks++; if (ser_wr_o !== 1'b0) $display("FAIL single_wr_early got %b exp 0", ser_wr_o); else n_pass++;
        tick();
        n_checks++; if (ser_wr_o !== 1'b1) $display("FAIL single_wr got %b exp 1", ser_wr_o); else n_pass++;
        n_checks++; if (ser_data_o !== 32'hABCDEF01) $display("FAIL single_data got %h exp abcdef01", ser_data_o); else n_pass++;
        n_checks++; if (level_o !== 4'd0) $display("FAIL single_level0 got %0d exp 0", level_o); else n_pass++;
        tick();
        n_checks++; if (ser_wr_o !== 1'b0) $display("FAIL single_wr_pulse got %b exp 0", ser_wr_o); else n_pass++;
        wait_rx(rx_base + 1, 200, "single");
        if (rx_q.size() > rx_base) begin
            n_checks++; if (rx_q[rx_base] !== 32'hABCDEF01) $display("FAIL single_rx_word got %h exp abcdef01", rx_q[rx_base]); else n_pass++;
            n_checks++; if (rxbits_q[rx_base] != 32) $display("FAIL single_rx_bits got %0d exp 32", rxbits_q[rx_base]); else n_pass++;
        end
        ticks(10);
        n_checks++; if (n_issue - iss_base != 1) $display("FAIL single_issue_count got %0d exp 1", n_issue - iss_base); else n_pass++;
        n_checks++; if (ser_data_o !== 32'hABCDEF01) $display("FAIL single_data_hold got %h exp abcdef01", ser_data_o); else n_pass++;
    endtask

    task automatic test_burst();
        int rx_base, g_base;
        logic [31:0] exp_w;
        rx_base = rx_q.size();
        g_base  = gap_q.size();
        use_model = 1'b0; man_cs = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_i = 1'b1; data_i = 32'(32'h11111111 * (i + 1));
            tick();
        end
        wr_i = 1'b0; data_i = '0;
        n_checks++; if (full_o !== 1'b1) $display("FAIL burst_full got %b exp 1", full_o); else n_pass++;
        n_checks++; if (level_o !== 4'd8) $display("FAIL burst_level got %0d exp 8", level_o); else n_pass++;
        use_model = 1'b1;
        wait_rx(rx_base + 8, 1500, "burst");
        for (int i = 0; i < 8; i++) begin
            exp_w = 32'(32'h11111111 * (i + 1));
            if (rx_q.size() > rx_base + i) begin
                n_checks++; if (rx_q[rx_base + i] !== exp_w) $display("FAIL burst_rx%0d got %h exp %h", i, rx_q[rx_base + i], exp_w); else n_pass++;
            end
        end
        for (int i = 1; i < 8; i++) begin
            if (gap_q.size() > g_base + i) begin
                n_checks++; if (gap_q[g_base + i] < GAP_CYCLES) $display("FAIL burst_gap%0d got %0d exp >=%0d", i, gap_q[g_base + i], GAP_CYCLES); else n_pass++;
            end
        end
        ticks(10);
        n_checks++; if (empty_o !== 1'b1) $display("FAIL burst_empty got %b exp 1", empty_o); else n_pass++;
    endtask

    task automatic test_overflow();
        int rx_base, iss_base;
        logic [31:0] exp_w;
        rx_base  = rx_q.size();
        iss_base = n_issue;
        use_model = 1'b0; man_cs = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr_i = 1'b1; data_i = 32'hA0000000 + 32'(i);
            tick();
        end
        wr_i = 1'b0; data_i = '0;
        n_checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow_o); else n_pass++;
        n_checks++; if (level_o !== 4'd8) $display("FAIL ovf_level got %0d exp 8", level_o); else n_pass++;
        n_checks++; if (full_o !== 1'b1) $display("FAIL ovf_full got %b exp 1", full_o); else n_pass++;
        use_model = 1'b1;
        wait_rx(rx_base + 8, 1500, "ovf");
        for (int i = 0; i < 8; i++) begin
            exp_w = 32'hA0000000 + 32'(i);
            if (rx_q.size() > rx_base + i) begin
                n_checks++; if (rx_q[rx_base + i] !== exp_w) $display("FAIL ovf_rx%0d got %h exp %h", i, rx_q[rx_base + i], exp_w); else n_pass++;
            end
        end
        ticks(150);
        n_checks++; if (n_issue - iss_base != 8) $display("FAIL ovf_issue_count got %0d exp 8", n_issue - iss_base); else n_pass++;
        n_checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow_o); else n_pass++;
    endtask

    task automatic test_flush();
        int rx_base, iss_base;
        rx_base  = rx_q.size();
        iss_base = n_issue;
        use_model = 1'b1;
        n_checks++; if (overflow_o !== 1'b1) $display("FAIL flush_pre_ovf got %b exp 1", overflow_o); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            wr_i = 1'b1; data_i = 32'hC0000000 + 32'(i);
            tick();
        end
        wr_i = 1'b0; data_i = '0;
        n_checks++; if (level_o !== 4'd5) $display("FAIL flush_pre_level got %0d exp 5", level_o); else n_pass++;
        ticks(5);
        flush_i = 1'b1; wr_i = 1'b1; data_i = 32'hDEADBEEF;
        tick();
        flush_i = 1'b0; wr_i = 1'b0; data_i = '0;
        n_checks++; if (level_o !== 4'd0) $display("FAIL flush_level got %0d exp 0", level_o); else n_pass++;
        n_checks++; if (empty_o !== 1'b1) $display("FAIL flush_empty got %b exp 1", empty_o); else n_pass++;
        n_checks++; if (overflow_o !== 1'b0) $display("FAIL flush_ovf got %b exp 0", overflow_o); else n_pass++;
        wait_rx(rx_base + 1, 200, "flush");
        if (rx_q.size() > rx_base) begin
            n_checks++; if (rx_q[rx_base] !== 32'hC0000000) $display("FAIL flush_inflight got %h exp c0000000", rx_q[rx_base]); else n_pass++;
        end
        ticks(150);
        n_checks++; if (n_issue - iss_base != 1) $display("FAIL flush_issue_count got %0d exp 1", n_issue - iss_base); else n_pass++;
        n_checks++; if (level_o !== 4'd0) $display("FAIL flush_level_after got %0d exp 0", level_o); else n_pass++;
    endtask

    task automatic test_timeout();
        int k;
        use_model = 1'b0; man_cs = 1'b1;
        wr_i = 1'b1; data_i = 32'h00000001;
        tick();
        data_i = 32'h00000002;
        tick();
        wr_i = 1'b0; data_i = '0;
        n_checks++; if (ser_wr_o !== 1'b1) $display("FAIL tmo_issue1 got %b exp 1", ser_wr_o); else n_pass++;
        n_checks++; if (ser_data_o !== 32'h1) $display("FAIL tmo_data1 got %h exp 1", ser_data_o); else n_pass++;
        ticks(START_TIMEOUT - 1);
        n_checks++; if (timeout_o !== 1'b0) $display("FAIL tmo_early got %b exp 0", timeout_o); else n_pass++;
        tick();
        n_checks++; if (timeout_o !== 1'b1) $display("FAIL tmo_flag got %b exp 1", timeout_o); else n_pass++;
        k = 0;
        while (ser_wr_o !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_checks++; if (k != GAP_CYCLES + 1) $display("FAIL tmo_gap_to_issue got %0d exp %0d", k, GAP_CYCLES + 1); else n_pass++;
        n_checks++; if (ser_data_o !== 32'h2) $display("FAIL tmo_data2 got %h exp 2", ser_data_o); else n_pass++;
        ticks(START_TIMEOUT + GAP_CYCLES + 4);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_checks++; if (timeout_o !== 1'b0) $display("FAIL tmo_flush_clear got %b exp 0", timeout_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int iss_base;
        use_model = 1'b0; man_cs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_i = 1'b1; data_i = 32'hE0000000 + 32'(i);
            tick();
        end
        wr_i = 1'b0;
        n_checks++; if (level_o !== 4'd3) $display("FAIL b2b_level_pre got %0d exp 3", level_o); else n_pass++;
        man_cs = 1'b1; wr_i = 1'b1; data_i = 32'hE0000003;
        tick();
        wr_i = 1'b0; data_i = '0; man_cs = 1'b0;
        n_checks++; if (level_o !== 4'd3) $display("FAIL b2b_level got %0d exp 3", level_o); else n_pass++;
        n_checks++; if (ser_wr_o !== 1'b1) $display("FAIL b2b_issue got %b exp 1", ser_wr_o); else n_pass++;
        n_checks++; if (ser_data_o !== 32'hE0000000) $display("FAIL b2b_data got %h exp e0000000", ser_data_o); else n_pass++;
        ticks(3);
        rst_n = 1'b0;
        tick();
        n_checks++; if (level_o !== 4'd0) $display("FAIL mrst_level got %0d exp 0", level_o); else n_pass++;
        n_checks++; if (empty_o !== 1'b1) $display("FAIL mrst_empty got %b exp 1", empty_o); else n_pass++;
        n_checks++; if (full_o !== 1'b0) $display("FAIL mrst_full got %b exp 0", full_o); else n_pass++;
        n_checks++; if (ser_wr_o !== 1'b0) $display("FAIL mrst_ser_wr got %b exp 0", ser_wr_o); else n_pass++;
        n_checks++; if (ser_data_o !== 32'h0) $display("FAIL mrst_ser_data got %h exp 0", ser_data_o); else n_pass++;
        rst_n = 1'b1; man_cs = 1'b1;
        iss_base = n_issue;
        ticks(20);
        n_checks++; if (n_issue - iss_base != 0) $display("FAIL mrst_no_issue got %0d exp 0", n_issue - iss_base); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_flush();
        test_timeout();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
